// File: rtl/bee_round_scheduler.sv
// Round controller for the bee-catching game: clears and releases the bee bank,
// gates capture, counts captures/score and ends the round on win or timeout.
module bee_round_scheduler #(
  parameter int NUM_BEES        = 4,
  parameter int INTERVAL_FRAMES = 120,
  parameter int ROUND_FRAMES    = 1800
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                frame_tick,
  input  logic                slug_can_catch,
  input  logic [NUM_BEES-1:0] bee_idle,
  input  logic [NUM_BEES-1:0] bee_caught,
  output logic                bee_reset,
  output logic [NUM_BEES-1:0] release_bee,
  output logic                can_capture,
  output logic [3:0]          caught_count,
  output logic [7:0]          score,
  output logic                playing,
  output logic                round_won,
  output logic                round_timeout
);

  localparam int REL_W = $clog2(INTERVAL_FRAMES) + 1;
  localparam int TMR_W = $clog2(ROUND_FRAMES) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_PLAYING = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          state_reg;
  logic [REL_W-1:0]    rel_cnt_reg;
  logic [TMR_W-1:0]    timer_reg;
  logic                first_rel_reg;
  logic                bee_reset_reg;
  logic [NUM_BEES-1:0] release_reg;
  logic [3:0]          caught_reg;
  logic [7:0]          score_reg;
  logic                won_reg;
  logic                timeout_reg;

  logic [3:0]          caught_pop;
  logic [4:0]          caught_sum;
  logic [3:0]          caught_next;
  logic [8:0]          score_sum;
  logic [7:0]          score_next;
  logic [REL_W-1:0]    rel_inc;
  logic                release_due;
  logic [NUM_BEES-1:0] release_pick;
  logic                all_caught;
  logic                timer_expired;

  always_comb begin
    caught_pop = '0;
    for (int i = 0; i < NUM_BEES; i++) begin
      caught_pop = caught_pop + {3'b000, bee_caught[i]};
    end
  end

  assign caught_sum  = {1'b0, caught_reg} + {1'b0, caught_pop};
  assign caught_next = (caught_sum > 5'(NUM_BEES)) ? 4'(NUM_BEES) : caught_sum[3:0];
  assign score_sum   = {1'b0, score_reg} + {5'b00000, caught_pop};
  assign score_next  = score_sum[8] ? 8'hFF : score_sum[7:0];

  assign rel_inc     = rel_cnt_reg + REL_W'(1);
  assign release_due = first_rel_reg || (rel_inc >= REL_W'(INTERVAL_FRAMES));
  // Two's-complement trick isolates the lowest set bit: lowest-index idle bee.
  assign release_pick = bee_idle & (~bee_idle + NUM_BEES'(1));

  assign all_caught    = (caught_reg == 4'(NUM_BEES));
  assign timer_expired = (timer_reg >= TMR_W'(ROUND_FRAMES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      rel_cnt_reg   <= '0;
      timer_reg     <= '0;
      first_rel_reg <= 1'b0;
      bee_reset_reg <= 1'b0;
      release_reg   <= '0;
      caught_reg    <= '0;
      score_reg     <= '0;
      won_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      bee_reset_reg <= 1'b0;
      release_reg   <= '0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg     <= S_CLEAR;
            bee_reset_reg <= 1'b1;
            caught_reg    <= '0;
            rel_cnt_reg   <= '0;
            timer_reg     <= '0;
            first_rel_reg <= 1'b0;
            won_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_reg     <= S_PLAYING;
          first_rel_reg <= 1'b1;
        end
        S_PLAYING: begin
          if (all_caught) begin
            state_reg <= S_DONE;
            won_reg   <= 1'b1;
          end else if (timer_expired && (caught_next != 4'(NUM_BEES))) begin
            // A final capture landing on the expiry cycle is let through so the win takes priority.
            state_reg   <= S_DONE;
            timeout_reg <= 1'b1;
          end else begin
            caught_reg <= caught_next;
            score_reg  <= score_next;
            if (frame_tick) begin
              timer_reg <= timer_reg + TMR_W'(1);
              if (release_due) begin
                release_reg   <= release_pick;
                rel_cnt_reg   <= '0;
                first_rel_reg <= 1'b0;
              end else begin
                rel_cnt_reg <= rel_inc;
              end
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bee_reset     = bee_reset_reg;
  assign release_bee   = release_reg;
  assign caught_count  = caught_reg;
  assign score         = score_reg;
  assign playing       = (state_reg == S_PLAYING);
  assign round_won     = won_reg;
  assign round_timeout = timeout_reg;
  assign can_capture   = playing & slug_can_catch;

endmodule

// File: tb/tb_bee_round_scheduler.sv
// Self-checking bench for bee_round_scheduler: scenario tasks checked against a
// round-level model (tick numbers, release schedule, capture/score arithmetic).
module tb_bee_round_scheduler;

  localparam int NB = 4;
  localparam int IV = 3;
  localparam int RF = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          frame_tick;
  logic          slug_can_catch;
  logic [NB-1:0] bee_idle;
  logic [NB-1:0] bee_caught;
  logic          bee_reset;
  logic [NB-1:0] release_bee;
  logic          can_capture;
  logic [3:0]    caught_count;
  logic [7:0]    score;
  logic          playing;
  logic          round_won;
  logic          round_timeout;

  int errors = 0;
  int checks = 0;
  int exp_score = 0;
  int exp_caught = 0;

  bee_round_scheduler #(
    .NUM_BEES(NB), .INTERVAL_FRAMES(IV), .ROUND_FRAMES(RF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .slug_can_catch(slug_can_catch), .bee_idle(bee_idle), .bee_caught(bee_caught),
    .bee_reset(bee_reset), .release_bee(release_bee), .can_capture(can_capture),
    .caught_count(caught_count), .score(score), .playing(playing),
    .round_won(round_won), .round_timeout(round_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic int popcnt(input logic [NB-1:0] v);
    int n = 0;
    for (int i = 0; i < NB; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [NB-1:0] lowest_of(input logic [NB-1:0] v);
    logic [NB-1:0] r = '0;
    for (int i = 0; i < NB; i++) begin
      if (v[i] && r == '0) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Release expected on tick t (1-based from round start): first tick and every IV after.
  function automatic bit release_tick(input int t);
    return ((t - 1) % IV) == 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_round();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    exp_caught = 0;
  endtask

  task automatic add_capture(input logic [NB-1:0] bc);
    exp_caught = (exp_caught + popcnt(bc) > NB) ? NB : exp_caught + popcnt(bc);
    exp_score  = (exp_score + popcnt(bc) > 255) ? 255 : exp_score + popcnt(bc);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; slug_can_catch = 1'b1;
    bee_idle = '1; bee_caught = '0;
    cyc(); cyc();
    checks++; if (bee_reset !== 1'b0) begin errors++; $display("FAIL reset_bee_reset: got %b want 0", bee_reset); end
    checks++; if (release_bee !== '0) begin errors++; $display("FAIL reset_release: got %b want 0000", release_bee); end
    checks++; if (caught_count !== 4'd0) begin errors++; $display("FAIL reset_caught: got %0d want 0", caught_count); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
    checks++; if (round_won !== 1'b0 || round_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: won=%b timeout=%b want 0/0", round_won, round_timeout); end
    checks++; if (can_capture !== 1'b0) begin errors++; $display("FAIL reset_can_capture: got %b want 0", can_capture); end
    @(negedge clk); reset = 1'b0;
    cyc(); cyc();
    checks++; if (playing !== 1'b0 || bee_reset !== 1'b0 || can_capture !== 1'b0) begin errors++; $display("FAIL idle_hold: playing=%b bee_reset=%b can_capture=%b want 0/0/0", playing, bee_reset, can_capture); end
    $display("reset: outputs cleared, idle holds");
  endtask

  task automatic test_release_schedule();
    logic [NB-1:0] released = '0;
    logic [NB-1:0] exp_rel;
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (bee_reset !== 1'b1) begin errors++; $display("FAIL clear_pulse: bee_reset=%b want 1", bee_reset); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL clear_playing: playing=%b want 0", playing); end
    frame_tick = 1'b1; bee_idle = '1;  // tick during CLEAR must be ignored
    cyc(); frame_tick = 1'b0;
    checks++; if (bee_reset !== 1'b0) begin errors++; $display("FAIL clear_one_cycle: bee_reset=%b want 0", bee_reset); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL enter_playing: playing=%b want 1", playing); end
    checks++; if (release_bee !== '0) begin errors++; $display("FAIL clear_tick_ignored: release_bee=%b want 0000", release_bee); end
    for (int t = 1; t <= RF; t++) begin
      int gap = 1 + $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc();
        checks++; if (release_bee !== '0) begin errors++; $display("FAIL release_gap t=%0d: release_bee=%b want 0000", t, release_bee); end
      end
      bee_idle = ~released; frame_tick = 1'b1;
      cyc(); frame_tick = 1'b0;
      exp_rel = release_tick(t) ? lowest_of(~released) : '0;
      released |= exp_rel;
      checks++; if (release_bee !== exp_rel) begin errors++; $display("FAIL release_tick%0d: release_bee=%b want %b", t, release_bee, exp_rel); end
      $display("tick %0d: release_bee=%b", t, release_bee);
    end
    cyc();
    checks++; if (round_timeout !== 1'b1 || round_won !== 1'b0) begin errors++; $display("FAIL timeout_flags: timeout=%b won=%b want 1/0", round_timeout, round_won); end
    checks++; if (playing !== 1'b0 || caught_count !== 4'd0) begin errors++; $display("FAIL timeout_state: playing=%b caught=%0d want 0/0", playing, caught_count); end
    bee_idle = '1; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
    checks++; if (release_bee !== '0 || round_timeout !== 1'b1) begin errors++; $display("FAIL done_no_release: release_bee=%b timeout=%b want 0000/1", release_bee, round_timeout); end
  endtask

  task automatic test_capture_win();
    logic [NB-1:0] seq [3] = '{4'b0001, 4'b0110, 4'b1000};
    slug_can_catch = 1'b1; bee_idle = '1;
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (caught_count !== 4'd0 || round_timeout !== 1'b0) begin errors++; $display("FAIL clear_zeroes: caught=%0d timeout=%b want 0/0", caught_count, round_timeout); end
    cyc();
    exp_caught = 0;
    for (int s = 0; s < 3; s++) begin
      bee_caught = seq[s];
      frame_tick = (s == 0);   // first release coincides with first capture
      start = (s == 1);        // start while playing must be ignored
      cyc();
      bee_caught = '0; frame_tick = 1'b0; start = 1'b0;
      add_capture(seq[s]);
      checks++; if (caught_count !== 4'(exp_caught)) begin errors++; $display("FAIL capture_count s%0d: got %0d want %0d", s, caught_count, exp_caught); end
      checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL capture_score s%0d: got %0d want %0d", s, score, exp_score); end
      if (s == 0) begin
        checks++; if (release_bee !== 4'b0001) begin errors++; $display("FAIL capture_with_release: release_bee=%b want 0001", release_bee); end
      end
      if (s == 2) begin
        checks++; if (bee_reset !== 1'b0) begin errors++; $display("FAIL start_ignored_playing: bee_reset=%b want 0", bee_reset); end
      end
      $display("capture %b: caught_count=%0d score=%0d", seq[s], caught_count, score);
    end
    cyc();
    checks++; if (round_won !== 1'b1 || round_timeout !== 1'b0) begin errors++; $display("FAIL win_flags: won=%b timeout=%b want 1/0", round_won, round_timeout); end
    checks++; if (playing !== 1'b0 || can_capture !== 1'b0) begin errors++; $display("FAIL win_state: playing=%b can_capture=%b want 0/0", playing, can_capture); end
    checks++; if (score !== 8'd4) begin errors++; $display("FAIL win_score: got %0d want 4", score); end
    bee_caught = '1; cyc(); bee_caught = '0;
    checks++; if (caught_count !== 4'd4 || score !== 8'(exp_score)) begin errors++; $display("FAIL done_capture_ignored: caught=%0d score=%0d want 4/%0d", caught_count, score, exp_score); end
  endtask

  task automatic test_can_capture();
    begin_round();
    checks++; if (caught_count !== 4'd0 || score !== 8'(exp_score)) begin errors++; $display("FAIL new_round: caught=%0d score=%0d want 0/%0d", caught_count, score, exp_score); end
    slug_can_catch = 1'b0; #1;
    checks++; if (can_capture !== 1'b0) begin errors++; $display("FAIL can_capture_slug0: got %b want 0", can_capture); end
    slug_can_catch = 1'b1; #1;
    checks++; if (can_capture !== 1'b1) begin errors++; $display("FAIL can_capture_slug1: got %b want 1", can_capture); end
    slug_can_catch = 1'b0; #1;
    checks++; if (can_capture !== 1'b0) begin errors++; $display("FAIL can_capture_toggle: got %b want 0", can_capture); end
    bee_caught = '1; cyc(); bee_caught = '0;
    add_capture('1);
    cyc();
    slug_can_catch = 1'b1; #1;
    checks++; if (round_won !== 1'b1 || can_capture !== 1'b0) begin errors++; $display("FAIL done_can_capture: won=%b can_capture=%b want 1/0", round_won, can_capture); end
    $display("can_capture: follows slug in play, blocked in done; score=%0d", score);
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 6; r++) begin
      int t = 0;
      int guard = 0;
      bit done = 0;
      logic [NB-1:0] exp_rel;
      logic [NB-1:0] bc;
      begin_round();
      while (!done && guard < 300) begin
        bit ft = ($urandom_range(0, 1) == 0);
        bc = ($urandom_range(0, 4) == 0) ? NB'($urandom_range(1, 15)) : '0;
        bee_idle = NB'($urandom_range(0, 15));
        frame_tick = ft; bee_caught = bc;
        cyc();
        frame_tick = 1'b0; bee_caught = '0;
        guard++;
        exp_rel = '0;
        if (ft) begin
          t++;
          if (release_tick(t)) exp_rel = lowest_of(bee_idle);
        end
        add_capture(bc);
        checks++; if (release_bee !== exp_rel) begin errors++; $display("FAIL rand_release r%0d t%0d: got %b want %b", r, t, release_bee, exp_rel); end
        checks++; if (caught_count !== 4'(exp_caught) || score !== 8'(exp_score)) begin errors++; $display("FAIL rand_count r%0d: caught=%0d score=%0d want %0d/%0d", r, caught_count, score, exp_caught, exp_score); end
        if (exp_caught == NB || t == RF) done = 1;
      end
      checks++; if (!done) begin errors++; $display("FAIL rand_budget r%0d: round did not end within %0d cycles", r, guard); end
      cyc();
      checks++; if (round_won !== (exp_caught == NB) || round_timeout !== (exp_caught != NB) || playing !== 1'b0) begin
        errors++; $display("FAIL rand_end r%0d: won=%b timeout=%b playing=%b want %b/%b/0", r, round_won, round_timeout, playing, exp_caught == NB, exp_caught != NB);
      end
      $display("round %0d: ticks=%0d caught=%0d score=%0d won=%b timeout=%b", r, t, caught_count, score, round_won, round_timeout);
    end
  endtask

  task automatic test_score_saturate();
    int rem;
    while (exp_score + NB <= 254) begin
      begin_round();
      bee_caught = '1; cyc(); bee_caught = '0;
      add_capture('1);
      cyc();
    end
    rem = 254 - exp_score;
    if (rem > 0) begin
      begin_round();
      bee_caught = NB'((1 << rem) - 1); cyc();
      add_capture(bee_caught);
      bee_caught = '0;
      for (int t = 0; t < RF; t++) begin
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
      end
      cyc();
    end
    checks++; if (score !== 8'd254) begin errors++; $display("FAIL preload_score: got %0d want 254", score); end
    begin_round();
    bee_caught = 4'b0111; cyc(); bee_caught = '0;
    checks++; if (score !== 8'd255 || caught_count !== 4'd3) begin errors++; $display("FAIL saturate_score: score=%0d caught=%0d want 255/3", score, caught_count); end
    bee_caught = 4'b1000; cyc(); bee_caught = '0;
    exp_score = 255;
    checks++; if (score !== 8'd255 || caught_count !== 4'd4) begin errors++; $display("FAIL saturate_hold: score=%0d caught=%0d want 255/4", score, caught_count); end
    cyc();
    checks++; if (round_won !== 1'b1) begin errors++; $display("FAIL saturate_win: won=%b want 1", round_won); end
    $display("score saturation: score=%0d", score);
  endtask

  task automatic test_reset_mid_round();
    slug_can_catch = 1'b1;
    begin_round();
    bee_idle = '1; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
    checks++; if (release_bee !== 4'b0001) begin errors++; $display("FAIL pending_release: got %b want 0001", release_bee); end
    #1 reset = 1'b1;
    #1;
    checks++; if (release_bee !== '0 || playing !== 1'b0 || can_capture !== 1'b0) begin errors++; $display("FAIL async_reset_a: release=%b playing=%b can_capture=%b want 0000/0/0", release_bee, playing, can_capture); end
    checks++; if (score !== 8'd0 || caught_count !== 4'd0 || bee_reset !== 1'b0) begin errors++; $display("FAIL async_reset_b: score=%0d caught=%0d bee_reset=%b want 0/0/0", score, caught_count, bee_reset); end
    @(negedge clk); reset = 1'b0;
    exp_score = 0;
    for (int c = 0; c < 8; c++) begin
      frame_tick = c[0]; bee_caught = NB'($urandom_range(0, 15)); bee_idle = '1;
      cyc();
      frame_tick = 1'b0; bee_caught = '0;
      checks++; if (release_bee !== '0 || bee_reset !== 1'b0 || playing !== 1'b0 || score !== 8'd0) begin
        errors++; $display("FAIL post_reset_quiet c%0d: release=%b bee_reset=%b playing=%b score=%0d want 0000/0/0/0", c, release_bee, bee_reset, playing, score);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (bee_reset !== 1'b1) begin errors++; $display("FAIL restart_after_reset: bee_reset=%b want 1", bee_reset); end
    $display("mid-round reset: aborted, restart ok");
  endtask

  initial begin
    test_reset();
    test_release_schedule();
    test_capture_win();
    test_can_capture();
    test_random_rounds();
    test_score_saturate();
    test_reset_mid_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bee_round_scheduler.md
# bee_round_scheduler

Round controller for the bee-catching game. It sequences a bank of NUM_BEES bee state machines through a round: it clears them, releases them one at a time on a frame-based schedule, and gates the shared capture-enable. It also counts captures, keeps the score and ends the round on all-caught or timeout. It sits between the top-level game FSM/buttons and the per-bee state machines.

## Interface
- NUM_BEES, 4, number of bee FSMs managed (1..8)
- INTERVAL_FRAMES, 120, frame ticks between successive releases (≥1)
- ROUND_FRAMES, 1800, frame ticks before round timeout (≥ INTERVAL_FRAMES)
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; one clock domain
- start  input  1  one-cycle synchronous pulse (debounced button) requesting a new round
- frame_tick  input  1  one-cycle pulse per video frame
- slug_can_catch  input  1  slug is in a catching posture
- bee_idle  input  NUM_BEES  bit i high while bee i is in its IDLE state
- bee_caught  input  NUM_BEES  bit i one-cycle pulse when bee i is captured
- bee_reset  output  1  one-cycle pulse returning all bees to IDLE
- release_bee  output  NUM_BEES  one-hot one-cycle pulse releasing bee i
- can_capture  output  1  broadcast capture enable to all bees
- caught_count  output  4  bees captured this round
- score  output  8  cumulative captures across rounds, saturating
- playing  output  1  high in PLAYING
- round_won  output  1  high in DONE if all bees caught
- round_timeout  output  1  high in DONE if timer expired

## Operation
- States: IDLE, CLEAR, PLAYING, DONE. Encoding is free.
- IDLE: wait. On start, go to CLEAR.
- CLEAR: lasts exactly one cycle. Asserts bee_reset. Zeroes caught_count, the release counter, the round timer, round_won and round_timeout. Next state is PLAYING.
- PLAYING transitions:
  - On frame_tick, increment the round timer and the release counter.
  - When the release counter reaches INTERVAL_FRAMES, or on the first frame_tick after entry, issue a release and reset the counter to 0.
  - A release pulses release_bee for the lowest-index i with bee_idle[i]=1. If no bee is idle, the release is a no-op and nothing is deferred.
  - Each bee_caught pulse adds the popcount of bee_caught to caught_count and to score. score saturates at 255.
  - When caught_count reaches NUM_BEES, set round_won and go to DONE.
  - Otherwise, when the round timer reaches ROUND_FRAMES, set round_timeout and go to DONE.
- DONE: hold the flags. On start, go to CLEAR.
- can_capture = playing & slug_can_catch. This is the registered playing flag ANDed combinationally with slug_can_catch.
- Ignored inputs:
  - bee_caught outside PLAYING.
  - start while in CLEAR or PLAYING.
- score is cleared only by reset; a new round does not clear it.

## Timing
- Reset, asynchronous, values:
  - State goes to IDLE.
  - bee_reset, release_bee, caught_count, score, playing, round_won and round_timeout are all 0.
  - can_capture is therefore 0.
- Reset mid-round aborts immediately. No release_bee or bee_reset pulse is emitted on reset exit.
- start at edge n: CLEAR during cycle n+1 (bee_reset=1), PLAYING from cycle n+2.
- Release timing:
  - release_bee is registered and is high for the cycle after the qualifying frame_tick.
  - bee_idle is sampled in the frame_tick cycle.
  - At most one bit of release_bee is set per pulse.
- Capture timing: caught_count and score update the cycle after the bee_caught pulse.
- DONE entry: the cycle after caught_count == NUM_BEES is registered, or after the timer compare.
- Simultaneous events:
  - Final capture and timeout in the same cycle: round_won wins and round_timeout stays 0.
  - Release and capture in the same cycle are both processed.
  - frame_tick in the CLEAR cycle is not counted.
- Widths:
  - Counters are sized by $clog2 of their parameter + 1.
  - caught_count is 4 bits and never exceeds NUM_BEES.

## Test plan
- Reset then start, NUM_BEES=4, INTERVAL_FRAMES=3: bee_reset=1 for exactly 1 cycle; then release_bee = 0001, 0010, 0100, 1000 on frame ticks 1, 4, 7 and 10.
- Capture all four bees (including two simultaneous bee_caught=0110) before timeout: caught_count counts 4; round_won=1; DONE; score=4; can_capture=0.
- With no captures and ROUND_FRAMES=20: round_timeout=1 on tick 20; caught_count=0; further ticks produce no release_bee.
- Second start after DONE: caught_count returns to 0 and score stays 4. With score preloaded to 254 through prior rounds and 3 captures, score=255.
- Assert reset mid-PLAYING while release_bee is pending: all outputs are 0 asynchronously; after release, nothing happens until start.
- Hold slug_can_catch=0 during PLAYING: can_capture=0. Toggling slug_can_catch follows combinationally; in IDLE or DONE, can_capture=0 regardless.
